// File: rtl/lcd_pixel_out.sv
// lcd_pixel_out: parallel-RGB panel timing generator that drains a show-ahead
// FIFO of packed RGB565 pixel pairs and serialises them one pixel per clock.
// A missing word in the active area is replaced by UNDERFLOW_COLOR. The pixel
// position keeps advancing, so sync timing is never disturbed.
// Optional feature: define LCD_PIXEL_OUT_UFCNT_EN to add the saturating
// underflow_cnt[15:0] output that counts missed words.
module lcd_pixel_out #(
  parameter int          H_ACTIVE        = 480,
  parameter int          H_FP            = 8,
  parameter int          H_SYNC          = 4,
  parameter int          H_BP            = 43,
  parameter int          V_ACTIVE        = 272,
  parameter int          V_FP            = 4,
  parameter int          V_SYNC          = 4,
  parameter int          V_BP            = 12,
  parameter logic        HS_POL          = 1'b0,
  parameter logic        VS_POL          = 1'b0,
  parameter logic [15:0] UNDERFLOW_COLOR = 16'hF800
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [31:0] rd_data,
  input  logic        rd_vld,
  output logic        rd_en,
  input  logic        underflow_clr,
  output logic        lcd_hs,
  output logic        lcd_vs,
  output logic        lcd_de,
  output logic [15:0] lcd_rgb,
  output logic        frame_start,
  output logic        underflow
`ifdef LCD_PIXEL_OUT_UFCNT_EN
  ,
  output logic [15:0] underflow_cnt
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e          state_q, state_d;
  logic [HW-1:0]   h_cnt_q, h_cnt_d;
  logic [VW-1:0]   v_cnt_q, v_cnt_d;

  logic            hs_q, hs_d;
  logic            vs_q, vs_d;
  logic            de_q, de_d;
  logic [15:0]     rgb_q, rgb_d;
  logic            fs_q, fs_d;
  logic [15:0]     hold_q, hold_d;
  logic            hold_ok_q, hold_ok_d;
  logic            underflow_q, underflow_d;

  logic            run;
  logic            active;
  logic            hs_act;
  logic            vs_act;
  logic            even_px;
  logic            miss;

  // Region decode straight from the registered counters.
  assign run     = (state_q == RUN);
  assign active  = (int'(h_cnt_q) < H_ACTIVE) && (int'(v_cnt_q) < V_ACTIVE);
  assign hs_act  = (int'(h_cnt_q) >= H_ACTIVE + H_FP) &&
                   (int'(h_cnt_q) <  H_ACTIVE + H_FP + H_SYNC);
  assign vs_act  = (int'(v_cnt_q) >= V_ACTIVE + V_FP) &&
                   (int'(v_cnt_q) <  V_ACTIVE + V_FP + V_SYNC);
  assign even_px = ~h_cnt_q[0];

  // A word is requested on every even active pixel. A request with an empty
  // FIFO is a missed word.
  assign rd_en = run & active & even_px;
  assign miss  = rd_en & ~rd_vld;

  // Next state and counters: run/stop decisions happen only at the frame wrap.
  always_comb begin
    state_d = state_q;
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    case (state_q)
      IDLE: begin
        h_cnt_d = '0;
        v_cnt_d = '0;
        if (en) state_d = RUN;
      end
      RUN: begin
        if (h_cnt_q == H_LAST) begin
          h_cnt_d = '0;
          if (v_cnt_q == V_LAST) begin
            v_cnt_d = '0;
            if (!en) state_d = IDLE;
          end else begin
            v_cnt_d = v_cnt_q + VW'(1);
          end
        end else begin
          h_cnt_d = h_cnt_q + HW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Next output values: sync, DE and pixel selection for the current position.
  always_comb begin
    hs_d      = ~HS_POL;
    vs_d      = ~VS_POL;
    de_d      = 1'b0;
    rgb_d     = 16'h0000;
    fs_d      = 1'b0;
    hold_d    = hold_q;
    hold_ok_d = hold_ok_q;
    if (run) begin
      if (hs_act) hs_d = HS_POL;
      if (vs_act) vs_d = VS_POL;
      fs_d = (h_cnt_q == '0) && (v_cnt_q == '0);
      if (active) begin
        de_d = 1'b1;
        if (even_px) begin
          if (rd_vld) begin
            rgb_d     = rd_data[15:0];
            hold_d    = rd_data[31:16];
            hold_ok_d = 1'b1;
          end else begin
            rgb_d     = UNDERFLOW_COLOR;
            hold_ok_d = 1'b0;
          end
        end else begin
          rgb_d = hold_ok_q ? hold_q : UNDERFLOW_COLOR;
        end
      end
    end
  end

  // Sticky underflow flag; a new miss beats a simultaneous clear.
  always_comb begin
    underflow_d = miss | (underflow_q & ~underflow_clr);
  end

  // State, counters, pixel hold and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      hs_q        <= ~HS_POL;
      vs_q        <= ~VS_POL;
      de_q        <= 1'b0;
      rgb_q       <= 16'h0000;
      fs_q        <= 1'b0;
      hold_q      <= 16'h0000;
      hold_ok_q   <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      de_q        <= de_d;
      rgb_q       <= rgb_d;
      fs_q        <= fs_d;
      hold_q      <= hold_d;
      hold_ok_q   <= hold_ok_d;
      underflow_q <= underflow_d;
    end
  end

  assign lcd_hs      = hs_q;
  assign lcd_vs      = vs_q;
  assign lcd_de      = de_q;
  assign lcd_rgb     = rgb_q;
  assign frame_start = fs_q;
  assign underflow   = underflow_q;

`ifdef LCD_PIXEL_OUT_UFCNT_EN
  logic [15:0] uf_cnt_q, uf_cnt_d;

  // Missed-word counter: saturating; clear together with a miss leaves 1.
  always_comb begin
    uf_cnt_d = uf_cnt_q;
    if (underflow_clr) begin
      uf_cnt_d = miss ? 16'd1 : 16'd0;
    end else if (miss && (uf_cnt_q != 16'hFFFF)) begin
      uf_cnt_d = uf_cnt_q + 16'd1;
    end
  end

  // Missed-word counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) uf_cnt_q <= 16'h0000;
    else        uf_cnt_q <= uf_cnt_d;
  end

  assign underflow_cnt = uf_cnt_q;
`endif

endmodule

// File: tb/tb_lcd_pixel_out.sv
// Bench for lcd_pixel_out on a small 8x5-clock frame geometry.
module tb_lcd_pixel_out;

  localparam int HA = 4, HF = 1, HS = 1, HB = 2;
  localparam int VA = 2, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [31:0] rd_data;
  logic        rd_vld;
  logic        rd_en;
  logic        underflow_clr;
  logic        lcd_hs, lcd_vs, lcd_de;
  logic [15:0] lcd_rgb;
  logic        frame_start;
  logic        underflow;
`ifdef LCD_PIXEL_OUT_UFCNT_EN
  logic [15:0] underflow_cnt;
`endif

  always #5 clk = ~clk;

  lcd_pixel_out #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .UNDERFLOW_COLOR(16'hF800)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .rd_data(rd_data), .rd_vld(rd_vld), .rd_en(rd_en),
    .underflow_clr(underflow_clr),
    .lcd_hs(lcd_hs), .lcd_vs(lcd_vs), .lcd_de(lcd_de), .lcd_rgb(lcd_rgb),
    .frame_start(frame_start), .underflow(underflow)
`ifdef LCD_PIXEL_OUT_UFCNT_EN
    , .underflow_cnt(underflow_cnt)
`endif
  );

  // Show-ahead FIFO model
  logic [31:0] fifo_mem [0:63];
  int          rd_ptr = 0;
  int          wr_ptr = 0;
  int          pop_cnt = 0;
  logic        starve;
  logic [15:0] sb [$];
  int          n_cmp = 0;
  int          n_fail = 0;
  logic        mon_on = 1'b0;
  logic        geo_on;
  int          c;
  int          base;

  assign rd_vld  = (rd_ptr != wr_ptr) && !starve;
  assign rd_data = fifo_mem[rd_ptr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at c=%0d: got %h expected %h", tag, c, obs, exp);
    end
  endtask

  // Scoreboard push: each word slot yields two expected pixels.
  always @(posedge clk) begin
    if (rd_en === 1'b1) begin
      if (rd_vld) begin
        sb.push_back(fifo_mem[rd_ptr][15:0]);
        sb.push_back(fifo_mem[rd_ptr][31:16]);
        rd_ptr  <= rd_ptr + 1;
        pop_cnt <= pop_cnt + 1;
      end else begin
        sb.push_back(16'hF800);
        sb.push_back(16'hF800);
      end
    end
  end

  // Scoreboard pop: every DE pixel must match the next expected value.
  always @(negedge clk) begin
    if (mon_on) begin
      if (lcd_de === 1'b1) begin
        check("sb_nonempty", (sb.size() > 0), 1);
        if (sb.size() > 0) check("pixel", lcd_rgb, sb.pop_front());
      end else begin
        check("blank_rgb", lcd_rgb, 16'h0000);
      end
    end
  end

  task automatic geo(input int p);
    int h, v, q;
    h = p % HT;
    v = p / HT;
    check("de", lcd_de, (h < HA && v < VA) ? 1 : 0);
    check("hs", lcd_hs, (h >= HA + HF && h < HA + HF + HS) ? 0 : 1);
    check("vs", lcd_vs, (v >= VA + VF && v < VA + VF + VS) ? 0 : 1);
    check("frame_start", frame_start, (p == 0) ? 1 : 0);
    if (p != FT - 1) begin
      q = p + 1;
      check("rd_en", rd_en, ((q % HT) < HA && (q / HT) < VA && (q % 2) == 0) ? 1 : 0);
    end
  endtask

  task automatic idle_chk();
    check("idle_de", lcd_de, 0);
    check("idle_hs", lcd_hs, 1);
    check("idle_vs", lcd_vs, 1);
    check("idle_rgb", lcd_rgb, 16'h0000);
    check("idle_fs", frame_start, 0);
    check("idle_rd_en", rd_en, 0);
  endtask

  task automatic adv(input int target);
    while (c < target) begin
      @(posedge clk);
      #1;
      c++;
      if (geo_on) geo((c - base) % FT);
      else        idle_chk();
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; starve = 1'b0; underflow_clr = 1'b0;
    geo_on = 1'b0; base = 0; c = -5;
    fifo_mem[0] = 32'h2222_1111;
    fifo_mem[1] = 32'h4444_3333;
    for (int k = 2; k < 64; k++)
      fifo_mem[k] = {16'hA000 + 16'(2 * k + 1), 16'hA000 + 16'(2 * k)};
    wr_ptr = 40;

    // reset held for three clocks with en high
    adv(-4);
    mon_on = 1'b1;
    check("rst_underflow", underflow, 0);
    adv(-2);
`ifdef LCD_PIXEL_OUT_UFCNT_EN
    check("rst_ufcnt", underflow_cnt, 0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1; c++;
    check("entry_de", lcd_de, 0);
    check("entry_fs", frame_start, 0);
    check("entry_rd_en", rd_en, 1);

    // frames 0 and 1, FIFO always valid
    geo_on = 1'b1;
    adv(0);  check("px0", lcd_rgb, 16'h1111);
    adv(1);  check("px1", lcd_rgb, 16'h2222);
    adv(2);  check("px2", lcd_rgb, 16'h3333);
    adv(3);  check("px3", lcd_rgb, 16'h4444);
    adv(7);  check("pops_line0", pop_cnt, 2);
    adv(79); check("pops_2frames", pop_cnt, 8);
    check("no_underflow", underflow, 0);

    // frame 2: second word slot of line 0 starved
    adv(81); check("uf_before", underflow, 0);
    starve = 1'b1;
    adv(82); starve = 1'b0;
    check("uf_px2", lcd_rgb, 16'hF800);
    check("uf_set", underflow, 1);
`ifdef LCD_PIXEL_OUT_UFCNT_EN
    check("ufcnt_1", underflow_cnt, 1);
`endif
    adv(83);  check("uf_px3", lcd_rgb, 16'hF800);
    adv(88);  check("line1_px0", lcd_rgb, 16'hA012);
    adv(89);  check("line1_px1", lcd_rgb, 16'hA013);
    adv(100); check("uf_sticky", underflow, 1);
    underflow_clr = 1'b1;
    adv(101); underflow_clr = 1'b0;
    check("uf_cleared", underflow, 0);
`ifdef LCD_PIXEL_OUT_UFCNT_EN
    check("ufcnt_clr", underflow_cnt, 0);
`endif

    // frame 3: three missed words, en dropped mid-frame
    adv(119); starve = 1'b1;
    adv(125); en = 1'b0;
    adv(128); starve = 1'b0;
    adv(159); check("uf_frame3", underflow, 1);
`ifdef LCD_PIXEL_OUT_UFCNT_EN
    check("ufcnt_3", underflow_cnt, 3);
`endif

    // idle after the frame boundary, then restart
    geo_on = 1'b0;
    adv(165); en = 1'b1;
    @(posedge clk); #1; c++;
    check("restart_fs0", frame_start, 0);
    check("restart_de0", lcd_de, 0);
    check("restart_rd_en", rd_en, 1);
    starve = 1'b1; underflow_clr = 1'b1;
    geo_on = 1'b1; base = 167;
    adv(167); starve = 1'b0; underflow_clr = 1'b0;
    check("restart_px0", lcd_rgb, 16'hF800);
    check("set_beats_clr", underflow, 1);
`ifdef LCD_PIXEL_OUT_UFCNT_EN
    check("ufcnt_clr_miss", underflow_cnt, 1);
`endif
    adv(200);
    check("sb_drained", sb.size(), 0);
    en = 1'b0;
    adv(206);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_pixel_out.md
# lcd_pixel_out

Downstream consumer of the LCD prefetch FIFO. Pops 32-bit words (two RGB565 pixels) through the FIFO's show-ahead `rd_en`/`rd_vld`/`rd_data` handshake. Generates parallel-RGB panel timing (HS/VS/DE) from parameterised porches. Serialises each word into two pixels, one per clock, aligned to DE. A FIFO underflow inside the active area is absorbed without losing frame lock.

## Interface
Parameters:
- `H_ACTIVE`, 480, active pixels per line; must be even
- `H_FP`, 8, horizontal front porch in clocks
- `H_SYNC`, 4, HS pulse width in clocks
- `H_BP`, 43, horizontal back porch in clocks
- `V_ACTIVE`, 272, active lines
- `V_FP`, 4, vertical front porch in lines
- `V_SYNC`, 4, VS pulse width in lines
- `V_BP`, 12, vertical back porch in lines
- `HS_POL`, 0, active level of `lcd_hs`
- `VS_POL`, 0, active level of `lcd_vs`
- `UNDERFLOW_COLOR`, 16'hF800, pixel value driven when no word is available

Ports:
- `clk`, in, 1: pixel clock; also the FIFO `rd_clk`
- `rst_n`, in, 1: reset, synchronous, active-low
- `en`, in, 1: run enable, sampled only at frame boundary
- `rd_data`, in, 32: FIFO head word; [15:0] is the first pixel, [31:16] the second
- `rd_vld`, in, 1: FIFO head valid
- `rd_en`, out, 1: pop request; a pop occurs when `rd_en & rd_vld`
- `underflow_clr`, in, 1: clears the sticky `underflow` flag
- `lcd_hs`, out, 1: horizontal sync
- `lcd_vs`, out, 1: vertical sync
- `lcd_de`, out, 1: data enable
- `lcd_rgb`, out, 16: RGB565 pixel
- `frame_start`, out, 1: one-clock pulse aligned with the first DE pixel of each frame
- `underflow`, out, 1: sticky flag set on any missed word

## Operation
- Derived widths:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
  - `h_cnt` width is $clog2(H_TOTAL); `v_cnt` width is $clog2(V_TOTAL).
- States:
  - IDLE:
    - Counters held at 0; `run`=0; outputs idle.
    - Moves to RUN when `en`=1.
  - RUN:
    - `h_cnt` counts 0..H_TOTAL-1 and wraps.
    - `v_cnt` increments on each `h_cnt` wrap and wraps at V_TOTAL-1.
    - At the wrap of the last clock of the frame (h=H_TOTAL-1, v=V_TOTAL-1): if `en`=0, go to IDLE; otherwise stay in RUN with counters returning to 0.
    - `en` deasserting mid-frame has no effect until that frame boundary.
- Regions, decoded from the counters:
  - Active: h<H_ACTIVE and v<V_ACTIVE.
  - HS active: H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, on every line.
  - VS active: V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, for whole lines.
- Pop rule: `rd_en` = `run` & active & (h[0]==0). This is combinational from registered state.
- Even active pixel:
  - If `rd_vld`=1: pop; output `rd_data[15:0]`; latch `rd_data[31:16]` into the hold register; `hold_ok`=1.
  - If `rd_vld`=0: no pop; output UNDERFLOW_COLOR; `hold_ok`=0; set `underflow`.
- Odd active pixel: output the hold register if `hold_ok`, otherwise UNDERFLOW_COLOR. No FIFO access.
- Underflow handling:
  - Pixel position is never stalled; each missed word is skipped.
  - The frame shifts content but keeps sync.
- Blanking: `lcd_rgb`=0 and `lcd_de`=0.
- `underflow` flag:
  - `underflow_clr` clears it.
  - If a set and a clear occur in the same cycle, the set wins.

## Timing
- Reset values:
  - `lcd_hs`=~HS_POL, `lcd_vs`=~VS_POL.
  - `lcd_de`=0, `lcd_rgb`=0, `frame_start`=0, `underflow`=0.
  - `rd_en`=0, state IDLE.
- Output registers:
  - `lcd_hs`/`lcd_vs`/`lcd_de`/`lcd_rgb`/`frame_start` are all registered.
  - They reflect counter state (h,v) one clock later and are mutually aligned.
- Pop vs pixel: the pop occurs in the clock where counters equal (h,v); the first pixel of that word appears on `lcd_rgb` on the next clock.
- Frame entry: with `en` high in IDLE, the cycle after the transition has h=v=0; the first DE/`frame_start` occurs 1 clock after that.
- FIFO rate: at most one pop every 2 clocks; no pops in blanking. This gives the FIFO fill time.

## Configuration
- `LCD_PIXEL_OUT_UFCNT_EN` defined:
  - Adds output `underflow_cnt[15:0]`, which counts missed words and saturates at 16'hFFFF.
  - Cleared by reset and by `underflow_clr`; if a clear and an increment coincide, the result is 1.
- Not defined: no port and no counter logic; `underflow` behaviour is unchanged.

## Test plan
Small configuration for all scenarios: H_ACTIVE=4, H_FP=1, H_SYNC=1, H_BP=2 (H_TOTAL=8); V_ACTIVE=2, V_FP=1, V_SYNC=1, V_BP=1 (V_TOTAL=5); polarities 0.
- Reset: hold `rst_n`=0 for 3 clocks with `en`=1 → `lcd_hs`=`lcd_vs`=1, `lcd_de`=0, `lcd_rgb`=0, `rd_en`=0 every cycle.
- Sync geometry: `en`=1, FIFO always valid →
  - `lcd_de` high 4 clocks per line on lines 0-1 only.
  - `lcd_hs` low 1 clock, starting 5 clocks after the DE rise.
  - `lcd_vs` low for exactly 8 clocks (line 3).
  - Period is 40 clocks; `frame_start` pulses once per 40 clocks.
- Unpacking: words 32'h2222_1111, 32'h4444_3333 → `lcd_rgb` = 1111, 2222, 3333, 4444 on consecutive DE clocks; exactly 2 pops per line.
- Underflow: `rd_vld`=0 during the second word slot of line 0 →
  - Pixels 2-3 are F800.
  - `underflow`=1 and stays set.
  - Line 1 still decodes correctly.
  - `underflow_clr` pulse → 0.
- Stop at boundary: drop `en` mid-frame 0 → frame 0 completes all 40 clocks, then IDLE with outputs at reset values; re-raise `en` → new `frame_start` after 2 clocks.
- With `LCD_PIXEL_OUT_UFCNT_EN`: 3 missed words → `underflow_cnt`=3; simultaneous clear and miss → 1.
